// File: rtl/bid_intake_arb.sv
// ============================================================================
// Module      : bid_intake_arb
// Description : Three-bidder intake with per-bidder FIFOs and a round-robin
//               arbiter feeding one registered output slot for the bids22 core.
//               Optional low-bid filter enabled by BID_INTAKE_MINBID_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bid_intake_arb #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             x_valid,
    input  logic             y_valid,
    input  logic             z_valid,
    input  logic [WIDTH-1:0] x_bid,
    input  logic [WIDTH-1:0] y_bid,
    input  logic [WIDTH-1:0] z_bid,
    output logic             x_ready,
    output logic             y_ready,
    output logic             z_ready,
    input  logic [WIDTH-1:0] min_bid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_id,
    output logic [WIDTH-1:0] out_bid,
    output logic [7:0]       reject_cnt
);

    localparam int              c_ptr_w   = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_ptr_one = 1;

    logic [2:0]             w_in_valid;
    logic [2:0][WIDTH-1:0]  w_in_bid;
    logic [3:0][WIDTH-1:0]  w_head;
    logic [2:0]             w_ready;
    logic [2:0]             w_nempty;
    logic [2:0]             w_full;
    logic [2:0]             w_push;
    logic [2:0]             w_pop;
    logic [2:0]             w_drop;
    logic [1:0]             w_grant;
    logic                   w_any;
    logic                   w_load;

    logic                   r_run;
    logic [1:0]             r_prio;
    logic                   r_out_valid;
    logic [1:0]             r_out_id;
    logic [WIDTH-1:0]       r_out_bid;

    assign w_in_valid = {z_valid, y_valid, x_valid};
    assign w_in_bid   = {z_bid, y_bid, x_bid};
    assign w_head[3]  = '0;

    // Ready depends only on registered pointers, so a same-edge pop never
    // frees a slot for a same-edge push.
    generate
        for (genvar b = 0; b < 3; b++) begin : g_fifo
            logic [WIDTH-1:0] r_mem [DEPTH];
            logic [c_ptr_w:0] r_wr;
            logic [c_ptr_w:0] r_rd;

            assign w_nempty[b] = (r_wr != r_rd);
            assign w_full[b]   = (r_wr[c_ptr_w] != r_rd[c_ptr_w]) &&
                                 (r_wr[c_ptr_w-1:0] == r_rd[c_ptr_w-1:0]);
            assign w_ready[b]  = r_run && !w_full[b];
            assign w_push[b]   = w_in_valid[b] && w_ready[b] && !w_drop[b];
            assign w_pop[b]    = w_load && w_any && (w_grant == 2'(b));
            assign w_head[b]   = r_mem[r_rd[c_ptr_w-1:0]];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_wr <= '0;
                    r_rd <= '0;
                end else begin
                    if (w_push[b]) r_wr <= r_wr + c_ptr_one;
                    if (w_pop[b])  r_rd <= r_rd + c_ptr_one;
                end
            end

            always_ff @(posedge clk) begin
                if (w_push[b]) r_mem[r_wr[c_ptr_w-1:0]] <= w_in_bid[b];
            end
        end
    endgenerate

    assign x_ready = w_ready[0];
    assign y_ready = w_ready[1];
    assign z_ready = w_ready[2];

    assign w_any  = |w_nempty;
    assign w_load = !r_out_valid || out_ready;

    always_comb begin
        w_grant = 2'd0;
        case (r_prio)
            2'd1: begin
                if (w_nempty[1])      w_grant = 2'd1;
                else if (w_nempty[2]) w_grant = 2'd2;
                else                  w_grant = 2'd0;
            end
            2'd2: begin
                if (w_nempty[2])      w_grant = 2'd2;
                else if (w_nempty[0]) w_grant = 2'd0;
                else                  w_grant = 2'd1;
            end
            default: begin
                if (w_nempty[0])      w_grant = 2'd0;
                else if (w_nempty[1]) w_grant = 2'd1;
                else                  w_grant = 2'd2;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run       <= 1'b0;
            r_prio      <= 2'd0;
            r_out_valid <= 1'b0;
            r_out_id    <= 2'd0;
            r_out_bid   <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_load) begin
                if (w_any) begin
                    r_out_valid <= 1'b1;
                    r_out_id    <= w_grant;
                    r_out_bid   <= w_head[w_grant];
                    r_prio      <= (w_grant == 2'd2) ? 2'd0 : w_grant + 2'd1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_id    = r_out_id;
    assign out_bid   = r_out_bid;

`ifdef BID_INTAKE_MINBID_EN
    logic [2:0] w_rej;
    logic [1:0] w_rej_n;
    logic [8:0] w_rej_sum;
    logic [7:0] r_reject_cnt;

    // Low bids are handshaken normally and then dropped before the FIFO.
    assign w_drop    = {w_in_bid[2] < min_bid, w_in_bid[1] < min_bid, w_in_bid[0] < min_bid};
    assign w_rej     = w_in_valid & w_ready & w_drop;
    assign w_rej_n   = {1'b0, w_rej[0]} + {1'b0, w_rej[1]} + {1'b0, w_rej[2]};
    assign w_rej_sum = {1'b0, r_reject_cnt} + {7'd0, w_rej_n};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                 r_reject_cnt <= 8'd0;
        else if (w_rej_sum > 9'd255)  r_reject_cnt <= 8'd255;
        else                          r_reject_cnt <= w_rej_sum[7:0];
    end

    assign reject_cnt = r_reject_cnt;
`else
    logic w_unused_minbid;

    assign w_drop          = 3'b000;
    assign reject_cnt      = 8'd0;
    assign w_unused_minbid = ^min_bid;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bid_intake_arb.sv
// ============================================================================
// Module      : tb_bid_intake_arb
// Description : Table-driven self-checking bench for bid_intake_arb, plus
//               hand-written reset and low-bid filter sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bid_intake_arb;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic             clk;
    logic             reset_n;
    logic             x_valid, y_valid, z_valid;
    logic [WIDTH-1:0] x_bid, y_bid, z_bid;
    logic             x_ready, y_ready, z_ready;
    logic [WIDTH-1:0] min_bid;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_id;
    logic [WIDTH-1:0] out_bid;
    logic [7:0]       reject_cnt;

    int checks = 0;
    int errors = 0;

    bid_intake_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .x_valid(x_valid), .y_valid(y_valid), .z_valid(z_valid),
        .x_bid(x_bid), .y_bid(y_bid), .z_bid(z_bid),
        .x_ready(x_ready), .y_ready(y_ready), .z_ready(z_ready),
        .min_bid(min_bid),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_id(out_id), .out_bid(out_bid),
        .reject_cnt(reject_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        xv;  logic [15:0] xb;
        logic        yv;  logic [15:0] yb;
        logic        zv;  logic [15:0] zb;
        logic        ordy;
        logic        eov; logic [1:0]  eid; logic [15:0] ebid;
        logic [2:0]  erdy;   // {z,y,x}
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic rst, logic xv, logic [15:0] xb, logic yv, logic [15:0] yb,
                               logic zv, logic [15:0] zb, logic ordy, logic eov, logic [1:0] eid,
                               logic [15:0] ebid, logic [2:0] erdy);
        vec_t r;
        r.rst = rst; r.xv = xv; r.xb = xb; r.yv = yv; r.yb = yb; r.zv = zv; r.zb = zb;
        r.ordy = ordy; r.eov = eov; r.eid = eid; r.ebid = ebid; r.erdy = erdy;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        x_valid = 0; y_valid = 0; z_valid = 0;
        x_bid = '0; y_bid = '0; z_bid = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse between edges; ends 1 time unit after an edge.
    task automatic do_reset();
        idle_inputs();
        out_ready = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
        chk("rst_out_bid", 32'(out_bid), 32'd0);
        chk("rst_ready", 32'({z_ready, y_ready, x_ready}), 32'd0);
        chk("rst_reject_cnt", 32'(reject_cnt), 32'd0);
        #1;
        reset_n = 1'b1;
        #1;
        chk("ready_before_edge", 32'({z_ready, y_ready, x_ready}), 32'd0);
        step();
        chk("ready_after_reset", 32'({z_ready, y_ready, x_ready}), 32'b111);
    endtask

    initial begin
        reset_n = 1'b1;
        min_bid = 16'd100;
        out_ready = 1'b0;
        idle_inputs();

        // Single X bid, latency 2, one cycle only
        tbl.push_back(v(1, 1,16'h0040, 0,0, 0,0, 1,  0,0,16'h0000, 3'b111));
        tbl.push_back(v(0, 0,0,        0,0, 0,0, 1,  1,0,16'h0040, 3'b111));
        tbl.push_back(v(0, 0,0,        0,0, 0,0, 1,  0,0,16'h0040, 3'b111));
        // X/Y/Z push two bids each -> X0,Y0,Z0,X1,Y1,Z1
        tbl.push_back(v(1, 1,16'h1000, 1,16'h2000, 1,16'h3000, 1,  0,0,16'h0000, 3'b111));
        tbl.push_back(v(0, 1,16'h1001, 1,16'h2001, 1,16'h3001, 1,  1,0,16'h1000, 3'b111));
        tbl.push_back(v(0, 0,0, 0,0, 0,0, 1,  1,1,16'h2000, 3'b111));
        tbl.push_back(v(0, 0,0, 0,0, 0,0, 1,  1,2,16'h3000, 3'b111));
        tbl.push_back(v(0, 0,0, 0,0, 0,0, 1,  1,0,16'h1001, 3'b111));
        tbl.push_back(v(0, 0,0, 0,0, 0,0, 1,  1,1,16'h2001, 3'b111));
        tbl.push_back(v(0, 0,0, 0,0, 0,0, 1,  1,2,16'h3001, 3'b111));
        tbl.push_back(v(0, 0,0, 0,0, 0,0, 1,  0,2,16'h3001, 3'b111));
        // Backpressure: Y fills FIFO plus output slot, sixth bid refused
        tbl.push_back(v(1, 0,0, 1,16'h5000, 0,0, 0,  0,0,16'h0000, 3'b111));
        tbl.push_back(v(0, 0,0, 1,16'h5001, 0,0, 0,  1,1,16'h5000, 3'b111));
        tbl.push_back(v(0, 0,0, 1,16'h5002, 0,0, 0,  1,1,16'h5000, 3'b111));
        tbl.push_back(v(0, 0,0, 1,16'h5003, 0,0, 0,  1,1,16'h5000, 3'b111));
        tbl.push_back(v(0, 0,0, 1,16'h5004, 0,0, 0,  1,1,16'h5000, 3'b101));
        tbl.push_back(v(0, 0,0, 1,16'h5005, 0,0, 0,  1,1,16'h5000, 3'b101));
        tbl.push_back(v(0, 0,0, 0,0,        0,0, 1,  1,1,16'h5001, 3'b111));
        tbl.push_back(v(0, 0,0, 0,0,        0,0, 1,  1,1,16'h5002, 3'b111));
        tbl.push_back(v(0, 0,0, 0,0,        0,0, 1,  1,1,16'h5003, 3'b111));
        tbl.push_back(v(0, 0,0, 0,0,        0,0, 1,  1,1,16'h5004, 3'b111));
        tbl.push_back(v(0, 0,0, 0,0,        0,0, 1,  0,1,16'h5004, 3'b111));

        // Power-up reset, checked before any clock edge
        #1 reset_n = 1'b0;
        #2;
        chk("por_out_valid", 32'(out_valid), 32'd0);
        chk("por_ready", 32'({z_ready, y_ready, x_ready}), 32'd0);
        chk("por_reject_cnt", 32'(reject_cnt), 32'd0);
        #1 reset_n = 1'b1;

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            x_valid = tbl[i].xv; x_bid = tbl[i].xb;
            y_valid = tbl[i].yv; y_bid = tbl[i].yb;
            z_valid = tbl[i].zv; z_bid = tbl[i].zb;
            out_ready = tbl[i].ordy;
            step();
            chk($sformatf("row%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].eov));
            chk($sformatf("row%0d_out_id", i), 32'(out_id), 32'(tbl[i].eid));
            chk($sformatf("row%0d_out_bid", i), 32'(out_bid), 32'(tbl[i].ebid));
            chk($sformatf("row%0d_ready", i), 32'({z_ready, y_ready, x_ready}), 32'(tbl[i].erdy));
        end
        idle_inputs();

        // Reset mid-stream with three bids queued and one held at the output
        do_reset();
        x_valid = 1; x_bid = 16'h00A0;
        y_valid = 1; y_bid = 16'h00B0;
        z_valid = 1; z_bid = 16'h00C0;
        step();
        idle_inputs();
        step();
        chk("mid_held_valid", 32'(out_valid), 32'd1);
        chk("mid_held_bid", 32'(out_bid), 32'h00A0);
        x_valid = 1; x_bid = 16'h00A1;
        step();
        idle_inputs();
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("no_stale_bid", 32'(out_valid), 32'd0);
        end
        y_valid = 1; y_bid = 16'h0077;
        step();
        y_valid = 0;
        chk("post_rst_latency1", 32'(out_valid), 32'd0);
        step();
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_id", 32'(out_id), 32'd1);
        chk("post_rst_bid", 32'(out_bid), 32'h0077);

`ifdef BID_INTAKE_MINBID_EN
        do_reset();
        out_ready = 1'b1;
        min_bid = 16'd100;
        z_valid = 1; z_bid = 16'd99;
        step();
        chk("minbid_rej1", 32'(reject_cnt), 32'd1);
        z_bid = 16'd100;
        step();
        chk("minbid_ready", 32'(z_ready), 32'd1);
        z_bid = 16'd50;
        step();
        chk("minbid_fwd_valid", 32'(out_valid), 32'd1);
        chk("minbid_fwd_id", 32'(out_id), 32'd2);
        chk("minbid_fwd_bid", 32'(out_bid), 32'd100);
        chk("minbid_rej2", 32'(reject_cnt), 32'd2);
        z_bid = 16'd1;
        for (int k = 0; k < 300; k++) step();
        z_valid = 0;
        chk("minbid_sat", 32'(reject_cnt), 32'd255);
        chk("minbid_no_low_out", 32'(out_valid), 32'd0);
`else
        do_reset();
        out_ready = 1'b1;
        min_bid = 16'd100;
        z_valid = 1; z_bid = 16'd99;
        step();
        z_valid = 0;
        step();
        chk("nofilter_valid", 32'(out_valid), 32'd1);
        chk("nofilter_id", 32'(out_id), 32'd2);
        chk("nofilter_bid", 32'(out_bid), 32'd99);
        chk("nofilter_reject_cnt", 32'(reject_cnt), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
